// File: rtl/timer_bank_pkg.sv
// Shared constants for timer_bank: register offsets, CTRL bit positions, mode encoding.
package timer_bank_pkg;
  localparam int OFF_CTRL  = 0;
  localparam int OFF_LOAD  = 1;
  localparam int OFF_CMP   = 2;
  localparam int OFF_COUNT = 3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_MODE_LSB  = 1;
  localparam int CTRL_IE        = 3;
  localparam int CTRL_PRESC_LSB = 4;
  localparam int CTRL_CHAIN     = 12;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_PWM      = 2'b10,
    MODE_PERIOD2  = 2'b11
  } mode_e;

  function automatic logic [5:0] irq_stat_idx(input int nch);
    return 6'(4 * nch);
  endfunction

  // Writable CTRL bits; everything else reads as zero.
  function automatic logic [31:0] ctrl_mask(input int psw, input bit chain);
    logic [31:0] m;
    m = 32'hF | (((32'd1 << psw) - 32'd1) << CTRL_PRESC_LSB);
    if (chain) m[CTRL_CHAIN] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/timer_bank_chan.sv
// One timer channel: CTRL/LOAD/CMP regs, prescaler, down-counter, output and expiry strobe.
// With TIMER_BANK_CASCADE_EN, channels above 0 may tick on the previous channel's expiry.
module timer_bank_chan
  import timer_bank_pkg::*;
#(
  parameter int CW  = 32,
  parameter int PSW = 8,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          RSTN,
  input  logic          i_wr_ctrl,
  input  logic          i_wr_load,
  input  logic          i_wr_cmp,
  input  logic [31:0]   i_wdata,
`ifdef TIMER_BANK_CASCADE_EN
  input  logic          i_chain,
`endif
  output logic [31:0]   o_ctrl,
  output logic [CW-1:0] o_load,
  output logic [CW-1:0] o_cmp,
  output logic [CW-1:0] o_count,
  output logic          o_expire,
  output logic          o_ie,
  output logic          o_out
);
`ifdef TIMER_BANK_CASCADE_EN
  localparam logic [31:0] MASK = ctrl_mask(PSW, IDX > 0);
`else
  localparam logic [31:0] MASK = ctrl_mask(PSW, 1'b0);
`endif

  logic [31:0]    r_ctrl;
  logic [CW-1:0]  r_load, r_cmp, r_count;
  logic [PSW-1:0] r_psc;
  logic           r_out;

  logic           w_en, w_psc_hit, w_tick_src, w_tick, w_expire, w_en_rise, w_oneshot;
  mode_e          w_mode;
  logic           w_unused;

  assign w_en      = r_ctrl[CTRL_EN];
  assign w_mode    = mode_e'(r_ctrl[CTRL_MODE_LSB +: 2]);
  assign w_oneshot = (w_mode == MODE_ONESHOT);
  assign w_psc_hit = (r_psc == r_ctrl[CTRL_PRESC_LSB +: PSW]);
`ifdef TIMER_BANK_CASCADE_EN
  assign w_tick_src = r_ctrl[CTRL_CHAIN] ? i_chain : w_psc_hit;
`else
  assign w_tick_src = w_psc_hit;
`endif
  // A bus CTRL write on the same edge swallows the tick.
  assign w_tick    = w_en && w_tick_src && !i_wr_ctrl;
  assign w_expire  = w_tick && (r_count == '0);
  assign w_en_rise = i_wr_ctrl && i_wdata[CTRL_EN] && !w_en;
  assign w_unused  = &{1'b0, i_wdata};

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_ctrl  <= '0;
      r_load  <= '0;
      r_cmp   <= '0;
      r_count <= '0;
      r_psc   <= '0;
      r_out   <= 1'b0;
    end else begin
      if (i_wr_ctrl)                  r_ctrl <= i_wdata & MASK;
      else if (w_expire && w_oneshot) r_ctrl[CTRL_EN] <= 1'b0;
      if (i_wr_load) r_load <= i_wdata[CW-1:0];
      if (i_wr_cmp)  r_cmp  <= i_wdata[CW-1:0];

      if (!w_en || w_psc_hit) r_psc <= '0;
      else                    r_psc <= r_psc + 1'b1;

      if (w_en_rise)                r_count <= r_load;
      else if (w_tick) begin
        if (r_count != '0)          r_count <= r_count - 1'b1;
        else if (!w_oneshot)        r_count <= r_load;
      end

      if (w_mode == MODE_PWM) r_out <= w_en && (r_count < r_cmp);
      else                    r_out <= w_expire;
    end
  end

  assign o_ctrl   = r_ctrl;
  assign o_load   = r_load;
  assign o_cmp    = r_cmp;
  assign o_count  = r_count;
  assign o_expire = w_expire;
  assign o_ie     = r_ctrl[CTRL_IE];
  assign o_out    = r_out;
endmodule

// File: rtl/timer_bank.sv
// Multi-channel memory-mapped timer: address decode, read mux, W1C IRQ_STAT and irq.
// Optional cascade between channels is built when TIMER_BANK_CASCADE_EN is defined.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int PSW = 8
) (
  input  logic           clk,
  input  logic           RSTN,
  input  logic           we,
  input  logic           re,
  input  logic [7:0]     addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic [NCH-1:0] ch_out,
  output logic           irq
);
  localparam logic [5:0] STAT_IDX = irq_stat_idx(NCH);

  logic [5:0]                w_word;
  logic [NCH-1:0][31:0]      w_ctrl;
  logic [NCH-1:0][CW-1:0]    w_load, w_cmp, w_count;
  logic [NCH-1:0]            w_expire, w_ie;
  logic [31:0]               w_rd;
  logic [NCH-1:0]            w_clr;
  logic [NCH-1:0]            r_stat;
  logic [31:0]               r_rdata;
  logic                      r_irq;
  logic                      w_unused;

  assign w_word   = addr[7:2];
  assign w_unused = &{1'b0, addr[1:0], wdata};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic w_wr_ctrl, w_wr_load, w_wr_cmp;
    assign w_wr_ctrl = we && (w_word == 6'(4*i + OFF_CTRL));
    assign w_wr_load = we && (w_word == 6'(4*i + OFF_LOAD));
    assign w_wr_cmp  = we && (w_word == 6'(4*i + OFF_CMP));
`ifdef TIMER_BANK_CASCADE_EN
    logic w_chain;
    if (i == 0) begin : g_head
      assign w_chain = 1'b0;
    end else begin : g_link
      assign w_chain = w_expire[i-1];
    end
`endif
    timer_bank_chan #(.CW(CW), .PSW(PSW), .IDX(i)) u_chan (
      .clk       (clk),
      .RSTN      (RSTN),
      .i_wr_ctrl (w_wr_ctrl),
      .i_wr_load (w_wr_load),
      .i_wr_cmp  (w_wr_cmp),
      .i_wdata   (wdata),
`ifdef TIMER_BANK_CASCADE_EN
      .i_chain   (w_chain),
`endif
      .o_ctrl    (w_ctrl[i]),
      .o_load    (w_load[i]),
      .o_cmp     (w_cmp[i]),
      .o_count   (w_count[i]),
      .o_expire  (w_expire[i]),
      .o_ie      (w_ie[i]),
      .o_out     (ch_out[i])
    );
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_word == 6'(4*i + OFF_CTRL))  w_rd = w_ctrl[i];
      if (w_word == 6'(4*i + OFF_LOAD))  w_rd = 32'(w_load[i]);
      if (w_word == 6'(4*i + OFF_CMP))   w_rd = 32'(w_cmp[i]);
      if (w_word == 6'(4*i + OFF_COUNT)) w_rd = 32'(w_count[i]);
    end
    if (w_word == STAT_IDX) w_rd = 32'(r_stat);
  end

  assign w_clr = (we && (w_word == STAT_IDX)) ? wdata[NCH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_stat  <= '0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      // New expiry beats a simultaneous W1C of the same bit.
      r_stat <= (r_stat & ~w_clr) | w_expire;
      if (re) r_rdata <= w_rd;
      r_irq <= |(r_stat & w_ie);
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;
endmodule
